// File: rtl/scs8hd_arb_pkg.sv
// Shared types for the scs8hd four-client round-robin arbiter.
package scs8hd_arb_pkg;
  localparam int NREQ = 4;

  typedef logic [1:0] req_idx_t;
  typedef logic [7:0] hold_cnt_t;

  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_e;
endpackage

// File: rtl/scs8hd_rr_pick4.sv
// Rotating priority picker: first candidate at or after start_i, wrapping modulo 4.
module scs8hd_rr_pick4
  import scs8hd_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  req_idx_t        start_i,
  input  logic [NREQ-1:0] excl_i,
  output logic            vld_o,
  output req_idx_t        win_o
);

  logic [NREQ-1:0] cand;
  req_idx_t        idx;
  logic            found;

  always_comb begin
    cand  = req_i & ~excl_i;
    found = 1'b0;
    win_o = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = start_i + req_idx_t'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win_o = idx;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/scs8hd_rrarb4b.sv
// Four-requester round-robin arbiter with registered one-hot grants (DN is active-low).
// Optional hold-limit preemption is enabled by defining SCS8HD_ARB_HOLD_LIMIT_EN.
module scs8hd_rrarb4b
  import scs8hd_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       DN,
  output logic       X,
  output logic       GA,
  output logic       GB,
  output logic       GC,
  output logic       GD,
  output logic [1:0] GNT_ID,
  output logic       BUSY
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 2..255");
  end

  logic [NREQ-1:0] req;
  arb_state_e      state_q, state_d;
  req_idx_t        ptr_q, ptr_d;
  req_idx_t        id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q;
  logic            pick_vld;
  req_idx_t        pick_win;
  req_idx_t        pick_start;
  logic [NREQ-1:0] pick_excl;
  logic            rotate;

  assign req = {~DN, C, B, A};
  assign X   = |req;

  // While granting, the same picker serves the handover scan starting after the owner.
  assign pick_start = (state_q == ST_GRANT) ? id_q + 2'd1 : ptr_q;
  assign pick_excl  = (state_q == ST_GRANT) ? gnt_q : '0;

  scs8hd_rr_pick4 u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .excl_i  (pick_excl),
    .vld_o   (pick_vld),
    .win_o   (pick_win)
  );

`ifdef SCS8HD_ARB_HOLD_LIMIT_EN
  hold_cnt_t cnt_q, cnt_d;
  logic      hold_sat;

  assign hold_sat = (cnt_q == hold_cnt_t'(HOLD_MAX - 1));
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    rotate  = 1'b0;
`ifdef SCS8HD_ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << pick_win;
          id_d    = pick_win;
`ifdef SCS8HD_ARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        rotate = ~req[id_q];
`ifdef SCS8HD_ARB_HOLD_LIMIT_EN
        rotate = rotate | (hold_sat & pick_vld);
        if (!rotate) cnt_d = hold_sat ? cnt_q : cnt_q + 8'd1;
`endif
        if (rotate) begin
          ptr_d = id_q + 2'd1;
          if (pick_vld) begin
            gnt_d = 4'b0001 << pick_win;
            id_d  = pick_win;
          end else begin
            gnt_d   = '0;
            id_d    = '0;
            state_d = ST_IDLE;
          end
`ifdef SCS8HD_ARB_HOLD_LIMIT_EN
          cnt_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef SCS8HD_ARB_HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      busy_q  <= |gnt_d;
`ifdef SCS8HD_ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign GA     = gnt_q[0];
  assign GB     = gnt_q[1];
  assign GC     = gnt_q[2];
  assign GD     = gnt_q[3];
  assign GNT_ID = id_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_scs8hd_rrarb4b.sv
// Directed table-driven bench for scs8hd_rrarb4b, plus a hold-limit sequence.
module tb_scs8hd_rrarb4b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, dn = 1'b1;
  logic       x, ga, gb, gc, gd, busy;
  logic [1:0] gnt_id;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SCS8HD_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  scs8hd_rrarb4b #(.HOLD_MAX(4)) dut (
    .CLK    (clk),
    .RESET  (rst),
    .A      (a),
    .B      (b),
    .C      (c),
    .DN     (dn),
    .X      (x),
    .GA     (ga),
    .GB     (gb),
    .GC     (gc),
    .GD     (gd),
    .GNT_ID (gnt_id),
    .BUSY   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       rst, a, b, c, dn;
    logic       x;
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  // g is the expected grant after the edge as {GD,GC,GB,GA}.
  function automatic vec_t mk(string nm, logic r, logic ia, logic ib, logic ic, logic idn,
                              logic [3:0] g);
    vec_t v;
    v.nm   = nm;
    v.rst  = r;
    v.a    = ia;
    v.b    = ib;
    v.c    = ic;
    v.dn   = idn;
    v.x    = ia | ib | ic | ~idn;
    v.g    = g;
    v.id   = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    v.busy = |g;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [6:0] act, exp;
    @(negedge clk);
    rst = v.rst; a = v.a; b = v.b; c = v.c; dn = v.dn;
    #1;
    n_cmp++;
    if (x !== v.x) begin
      n_bad++;
      $display("FAIL %s X: got %b want %b", v.nm, x, v.x);
    end
    @(posedge clk);
    #1;
    act = {gd, gc, gb, ga, gnt_id, busy};
    exp = {v.g, v.id, v.busy};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s {GD,GC,GB,GA,ID,BUSY}: got %b want %b", v.nm, act, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;

    // reset state and DN active-low request
    tbl.push_back(mk("rst",       1, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mk("idle",      0, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mk("dn_req",    0, 0, 0, 0, 0, 4'b1000));
    tbl.push_back(mk("dn_drop",   0, 0, 0, 0, 1, 4'b0000));
    // full rotation, each client drops 3 cycles after its grant
    tbl.push_back(mk("rr_rst",    1, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mk("rr_a0",     0, 1, 1, 1, 0, 4'b0001));
    tbl.push_back(mk("rr_a1",     0, 1, 1, 1, 0, 4'b0001));
    tbl.push_back(mk("rr_a2",     0, 1, 1, 1, 0, 4'b0001));
    tbl.push_back(mk("rr_b0",     0, 0, 1, 1, 0, 4'b0010));
    tbl.push_back(mk("rr_b1",     0, 1, 1, 1, 0, 4'b0010));
    tbl.push_back(mk("rr_b2",     0, 1, 1, 1, 0, 4'b0010));
    tbl.push_back(mk("rr_c0",     0, 1, 0, 1, 0, 4'b0100));
    tbl.push_back(mk("rr_c1",     0, 1, 1, 1, 0, 4'b0100));
    tbl.push_back(mk("rr_c2",     0, 1, 1, 1, 0, 4'b0100));
    tbl.push_back(mk("rr_d0",     0, 1, 1, 0, 0, 4'b1000));
    tbl.push_back(mk("rr_d1",     0, 1, 1, 1, 0, 4'b1000));
    tbl.push_back(mk("rr_d2",     0, 1, 1, 1, 0, 4'b1000));
    tbl.push_back(mk("rr_a_again",0, 1, 1, 1, 1, 4'b0001));
    // handover scan and pointer persistence
    tbl.push_back(mk("ho_rst",    1, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mk("ho_b",      0, 0, 1, 0, 1, 4'b0010));
    tbl.push_back(mk("ho_b_to_a", 0, 1, 0, 0, 1, 4'b0001));
    tbl.push_back(mk("ho_a_to_b", 0, 0, 1, 1, 1, 4'b0010));
    tbl.push_back(mk("ho_b_to_c", 0, 0, 0, 1, 1, 4'b0100));
    tbl.push_back(mk("ho_c_drop", 0, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mk("ho_ab_p3",  0, 1, 1, 0, 1, 4'b0001));
    // reset mid-grant with pointer previously moved to 2
    tbl.push_back(mk("mr_rst",    1, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mk("mr_b",      0, 0, 1, 0, 1, 4'b0010));
    tbl.push_back(mk("mr_b_drop", 0, 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mk("mr_a",      0, 1, 0, 0, 1, 4'b0001));
    tbl.push_back(mk("mr_a_c",    0, 1, 0, 1, 1, 4'b0001));
    tbl.push_back(mk("mr_reset",  1, 1, 0, 1, 1, 4'b0000));
    tbl.push_back(mk("mr_release",0, 1, 0, 1, 1, 4'b0001));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // A and B both held: alternate every 4 grants with hold limit, else A forever
    apply(mk("h_rst", 1, 0, 0, 0, 1, 4'b0000));
    for (int n = 0; n < 16; n++) begin
      exp_g = (HOLD_EN && ((n / 4) % 2 == 1)) ? 4'b0010 : 4'b0001;
      apply(mk($sformatf("hold_ab%0d", n), 0, 1, 1, 0, 1, exp_g));
    end
    for (int n = 0; n < 8; n++) begin
      apply(mk($sformatf("hold_a_only%0d", n), 0, 1, 0, 0, 1, 4'b0001));
    end
    exp_g = HOLD_EN ? 4'b0010 : 4'b0001;
    apply(mk("hold_sat_b_returns", 0, 1, 1, 0, 1, exp_g));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scs8hd_rrarb4b.md
Name: scs8hd_rrarb4b

Overview:
- Four-requester round-robin arbiter for sharing one resource between four clients.
- The request front end is the same OR4-with-inverted-D function used in the library: A, B and C are active-high requests, and DN is an active-low request.
- Produces registered one-hot grants, a grant index, and a combinational any-request output X.
- Sits in front of a shared datapath port. The grant sequences which client drives that port.

Parameters:
- HOLD_MAX, 8, maximum consecutive grant cycles for one client while another client is waiting. Legal range is 2..255. Used only when SCS8HD_ARB_HOLD_LIMIT_EN is defined.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous reset, active-high.
- A  input  1  request 0, active-high.
- B  input  1  request 1, active-high.
- C  input  1  request 2, active-high.
- DN  input  1  request 3, active-low.
- X  output  1  combinational any-request, X = A | B | C | ~DN.
- GA  output  1  registered grant for A.
- GB  output  1  registered grant for B.
- GC  output  1  registered grant for C.
- GD  output  1  registered grant for DN.
- GNT_ID  output  2  index of the current grant (0=A, 1=B, 2=C, 3=DN); 0 when no grant.
- BUSY  output  1  registered; 1 when any grant is asserted.

Behaviour:
- Internal request vector: r = {~DN, C, B, A}, so r[3] is the DN client.
- Reset (RESET=1 at an edge, overrides everything):
  - GA..GD=0, GNT_ID=0, BUSY=0.
  - Priority pointer ptr=0, so A has highest priority.
  - State IDLE, hold counter=0.
  - X is not reset; it follows its inputs combinationally at all times.
- Grants are one-hot or zero. Two grants are never asserted together.
- State IDLE:
  - If any r[i]=1, the next edge grants the winner and moves to GRANT.
  - Winner = first set bit scanning ptr, ptr+1, ... modulo 4.
  - Latency from request to grant is 1 cycle.
- State GRANT, granted client g:
  - While r[g]=1, the grant is held.
  - The cycle after r[g] is seen low at an edge:
    - ptr <= (g+1) mod 4.
    - If other requests are present, the grant moves directly to the winner scanned from (g+1) mod 4. There is no idle bubble and the state stays GRANT.
    - Otherwise all grants drop and the state goes to IDLE.
- A request that drops before it is granted is simply not granted. There is no request latching.
- Hold counter:
  - Clears on every new grant.
  - Increments each GRANT cycle and saturates at HOLD_MAX-1.
  - Width is 8 bits.
- Simultaneous requests are resolved only by ptr. The pointer advances only when a grant ends.
- Reset asserted mid-grant: grants are 0 on the next edge, and ptr returns to 0.

Optional Feature:
- Macro: SCS8HD_ARB_HOLD_LIMIT_EN.
- Defined:
  - In GRANT, if the counter reaches HOLD_MAX-1 and some r[j]=1 with j≠g, the next edge forces rotation.
  - The grant moves to the winner scanned from (g+1) mod 4, excluding g, and ptr <= (g+1) mod 4.
  - If no other client is requesting, g keeps the grant and the counter stays saturated.
- Undefined:
  - No preemption; the grant is held until r[g] drops.
  - The counter logic is not compiled, and HOLD_MAX is ignored.

Decomposition:
- Package scs8hd_arb_pkg contains:
  - NREQ=4.
  - typedef req_idx_t (2 bits).
  - State enum {ST_IDLE, ST_GRANT}.
  - typedef hold_cnt_t (8 bits).
- Sub-module scs8hd_rr_pick4 (combinational):
  - Inputs: 4-bit request vector, 2-bit start pointer, 4-bit exclude mask.
  - Outputs: valid, 2-bit winner index.
  - Used for both the IDLE and the handover paths.

Test Plan:
- Reset, then A=B=C=0 and DN=1 -> X=0, all grants 0, BUSY=0. Next DN=0 -> X=1 in the same cycle; one edge later GD=1, GNT_ID=3, BUSY=1.
- After reset, A=B=C=1 and DN=0 held, with each client dropping its request 3 cycles after being granted and reasserting afterwards -> grant order A, B, C, DN, A with no idle cycle between handovers.
- Grant on B, then B drops while A=1 -> next grant is A, because ptr=2 scans C, DN, A and only A is requesting. Then ptr=1.
- With A held high and C requesting, RESET pulsed 1 cycle while GA=1 -> next edge all grants 0 and ptr=0; one edge after release GA=1.
- SCS8HD_ARB_HOLD_LIMIT_EN defined, HOLD_MAX=4, A and B held high -> GA high for 4 cycles, then GB for 4, alternating. With only A high -> GA held indefinitely.
- Same stimulus with the macro undefined -> GA held indefinitely and GB never asserted.
